// File: rtl/stq_drain_controller_if.sv
// stq_drain_controller_if: lsu_pkg widths plus the head/memory/completion bundle of the store drain controller.
// master is the controller side, slave is the store queue / memory side.
package lsu_pkg;
    parameter int XLEN = 32;
    parameter int ROB_TAG_WIDTH = 6;
endpackage

interface stq_drain_if #(
    parameter int XLEN = lsu_pkg::XLEN,
    parameter int ROB_TAG_WIDTH = lsu_pkg::ROB_TAG_WIDTH
);
    logic                     head_valid;
    logic                     head_committed;
    logic                     head_address_valid;
    logic                     head_data_valid;
    logic [XLEN-1:0]          head_address;
    logic [XLEN-1:0]          head_data;
    logic [ROB_TAG_WIDTH-1:0] head_rob_tag;
    logic                     drain_stall;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [XLEN-1:0]          mem_req_addr;
    logic [XLEN-1:0]          mem_req_data;
    logic                     mem_resp_valid;
    logic                     mem_resp_error;
    logic                     store_succeeded;
    logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag;
    logic                     stq_pop;
    logic                     drain_busy;

    modport master (
        input  head_valid, head_committed, head_address_valid, head_data_valid,
               head_address, head_data, head_rob_tag, drain_stall,
               mem_req_ready, mem_resp_valid, mem_resp_error,
        output mem_req_valid, mem_req_addr, mem_req_data,
               store_succeeded, store_succeeded_rob_tag, stq_pop, drain_busy
    );

    modport slave (
        output head_valid, head_committed, head_address_valid, head_data_valid,
               head_address, head_data, head_rob_tag, drain_stall,
               mem_req_ready, mem_resp_valid, mem_resp_error,
        input  mem_req_valid, mem_req_addr, mem_req_data,
               store_succeeded, store_succeeded_rob_tag, stq_pop, drain_busy
    );
endinterface

// File: rtl/stq_drain_controller.sv
// stq_drain_controller: drains the committed store-queue head to memory, reissuing on error.
// STQ_DRAIN_PERF_COUNTER_EN adds drained_count/retry_count outputs.
module stq_drain_controller (
    input  logic        clk,
    input  logic        reset,
    stq_drain_if.master bus
`ifdef STQ_DRAIN_PERF_COUNTER_EN
    ,
    output logic [31:0] drained_count,
    output logic [31:0] retry_count
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RETIRE} state_t;

    state_t state, next_state;
    logic [lsu_pkg::XLEN-1:0]          addr_q, data_q;
    logic [lsu_pkg::ROB_TAG_WIDTH-1:0] tag_q;
    logic eligible, resp_ok, resp_err;

    assign eligible = bus.head_valid && bus.head_committed && bus.head_address_valid &&
                      bus.head_data_valid && !bus.drain_stall;
    assign resp_ok  = state == WAIT_RESP && bus.mem_resp_valid && !bus.mem_resp_error;
    assign resp_err = state == WAIT_RESP && bus.mem_resp_valid && bus.mem_resp_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = eligible ? REQ : IDLE;
            REQ:       next_state = bus.mem_req_ready ? WAIT_RESP : REQ;
            WAIT_RESP: next_state = resp_ok ? RETIRE : resp_err ? REQ : WAIT_RESP;
            RETIRE:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // The request is captured once per drain so later head changes cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
        end else if (state == IDLE && eligible) begin
            addr_q <= bus.head_address;
            data_q <= bus.head_data;
            tag_q  <= bus.head_rob_tag;
        end
    end

    assign bus.mem_req_valid           = state == REQ;
    assign bus.mem_req_addr            = addr_q;
    assign bus.mem_req_data            = data_q;
    assign bus.store_succeeded         = state == RETIRE;
    assign bus.store_succeeded_rob_tag = state == RETIRE ? tag_q : '0;
    assign bus.stq_pop                 = state == RETIRE;
    assign bus.drain_busy              = state != IDLE;

`ifdef STQ_DRAIN_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drained_count <= '0;
            retry_count   <= '0;
        end else begin
            if (state == RETIRE) drained_count <= drained_count + 32'd1;
            if (resp_err) retry_count <= retry_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stq_drain_controller.sv
// tb_stq_drain_controller: directed scenario tests for stq_drain_controller.
module tb_stq_drain_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    stq_drain_if bus ();

`ifdef STQ_DRAIN_PERF_COUNTER_EN
    logic [31:0] drained_count, retry_count;
    stq_drain_controller dut (.clk(clk), .reset(reset), .bus(bus),
                              .drained_count(drained_count), .retry_count(retry_count));
`else
    stq_drain_controller dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic [31:0] a, input logic [31:0] d, input logic [5:0] t);
        bus.head_valid = 1'b1;
        bus.head_committed = 1'b1;
        bus.head_address_valid = 1'b1;
        bus.head_data_valid = 1'b1;
        bus.head_address = a;
        bus.head_data = d;
        bus.head_rob_tag = t;
    endtask

    task automatic clear_inputs;
        bus.head_valid = 1'b0;
        bus.head_committed = 1'b0;
        bus.head_address_valid = 1'b0;
        bus.head_data_valid = 1'b0;
        bus.head_address = '0;
        bus.head_data = '0;
        bus.head_rob_tag = '0;
        bus.drain_stall = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_error = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        set_head(32'h0000_0AAA, 32'h0000_0BBB, 6'd2);
        tick();
        tick();
        total++;
        if ({bus.mem_req_valid, bus.store_succeeded, bus.stq_pop, bus.drain_busy} !== 4'b0 ||
            bus.mem_req_addr !== 32'h0 || bus.mem_req_data !== 32'h0 || bus.store_succeeded_rob_tag !== 6'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b succ=%b pop=%b busy=%b addr=%h data=%h tag=%h, want all 0",
                     bus.mem_req_valid, bus.store_succeeded, bus.stq_pop, bus.drain_busy,
                     bus.mem_req_addr, bus.mem_req_data, bus.store_succeeded_rob_tag);
        end
        clear_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        set_head(32'h1000, 32'hDEAD_BEEF, 6'd5);
        bus.mem_req_ready = 1'b1;
        tick();
        total++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h1000 || bus.mem_req_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_req: valid=%b addr=%h data=%h, want 1 00001000 deadbeef",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data);
        end
        bus.head_valid = 1'b0;
        bus.head_address = 32'h2222;
        tick();
        total++;
        if (bus.mem_req_valid !== 1'b0 || bus.drain_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_wait: valid=%b busy=%b, want 0 1", bus.mem_req_valid, bus.drain_busy);
        end
        bus.mem_resp_valid = 1'b1;
        tick();
        total++;
        if (bus.store_succeeded !== 1'b1 || bus.stq_pop !== 1'b1 || bus.store_succeeded_rob_tag !== 6'd5) begin
            bad++;
            $display("FAIL single_retire: succ=%b pop=%b tag=%0d, want 1 1 5",
                     bus.store_succeeded, bus.stq_pop, bus.store_succeeded_rob_tag);
        end
        bus.mem_resp_valid = 1'b0;
        tick();
        total++;
        if (bus.store_succeeded !== 1'b0 || bus.stq_pop !== 1'b0 || bus.drain_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: succ=%b pop=%b busy=%b, want 0 0 0",
                     bus.store_succeeded, bus.stq_pop, bus.drain_busy);
        end
    endtask

    task automatic test_ready_stall;
        int pops = 0;
        bus.mem_req_ready = 1'b0;
        set_head(32'h3000, 32'h1234_5678, 6'd7);
        tick();
        bus.head_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h3000 || bus.mem_req_data !== 32'h1234_5678) begin
                bad++;
                $display("FAIL stall_stable[%0d]: valid=%b addr=%h data=%h, want 1 00003000 12345678",
                         i, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data);
            end
            if (i == 3) bus.mem_req_ready = 1'b1;
            tick();
        end
        total++;
        if (bus.mem_req_valid !== 1'b0 || bus.drain_busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_accept: valid=%b busy=%b, want 0 1", bus.mem_req_valid, bus.drain_busy);
        end
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.mem_resp_valid = 1'b0;
            if (bus.stq_pop === 1'b1) begin
                pops++;
                total++;
                if (bus.store_succeeded_rob_tag !== 6'd7) begin
                    bad++;
                    $display("FAIL stall_tag: got %0d want 7", bus.store_succeeded_rob_tag);
                end
            end
        end
        total++;
        if (pops != 1) begin
            bad++;
            $display("FAIL stall_pops: got %0d want 1", pops);
        end
    endtask

    task automatic test_error_retry;
        int succ = 0;
        bus.mem_req_ready = 1'b1;
        set_head(32'h4000, 32'h0BAD_F00D, 6'd9);
        tick();
        bus.head_valid = 1'b0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_error = 1'b1;
        tick();
        total++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h4000 || bus.mem_req_data !== 32'h0BAD_F00D ||
            bus.store_succeeded !== 1'b0) begin
            bad++;
            $display("FAIL retry_reissue: valid=%b addr=%h data=%h succ=%b, want 1 00004000 0badf00d 0",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data, bus.store_succeeded);
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_error = 1'b0;
        tick();
        total++;
        if (bus.mem_req_valid !== 1'b0 || bus.drain_busy !== 1'b1) begin
            bad++;
            $display("FAIL retry_wait: valid=%b busy=%b, want 0 1", bus.mem_req_valid, bus.drain_busy);
        end
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.mem_resp_valid = 1'b0;
            if (bus.store_succeeded === 1'b1) succ++;
        end
        total++;
        if (succ != 1) begin
            bad++;
            $display("FAIL retry_succeeded: got %0d want 1", succ);
        end
`ifdef STQ_DRAIN_PERF_COUNTER_EN
        total++;
        if (retry_count !== 32'd1) begin
            bad++;
            $display("FAIL retry_count: got %0d want 1", retry_count);
        end
`endif
    endtask

    task automatic test_no_drain;
        for (int c = 0; c < 3; c++) begin
            int hits = 0;
            set_head(32'h7000, 32'h77, 6'd4);
            if (c == 0) bus.head_committed = 1'b0;
            if (c == 1) bus.head_data_valid = 1'b0;
            if (c == 2) bus.drain_stall = 1'b1;
            bus.mem_req_ready = 1'b1;
            bus.mem_resp_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (bus.mem_req_valid !== 1'b0 || bus.drain_busy !== 1'b0 || bus.store_succeeded !== 1'b0) hits++;
            end
            total++;
            if (hits != 0) begin
                bad++;
                $display("FAIL no_drain[%0d]: active cycles=%0d want 0", c, hits);
            end
            clear_inputs();
            tick();
        end
    endtask

    task automatic test_reset_mid;
        int hits = 0;
        bus.mem_req_ready = 1'b1;
        set_head(32'h5000, 32'h55, 6'd3);
        tick();
        bus.head_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.mem_req_valid, bus.store_succeeded, bus.stq_pop, bus.drain_busy} !== 4'b0 ||
            bus.mem_req_addr !== 32'h0 || bus.mem_req_data !== 32'h0 || bus.store_succeeded_rob_tag !== 6'h0) begin
            bad++;
            $display("FAIL async_reset: valid=%b succ=%b pop=%b busy=%b addr=%h data=%h tag=%h, want all 0",
                     bus.mem_req_valid, bus.store_succeeded, bus.stq_pop, bus.drain_busy,
                     bus.mem_req_addr, bus.mem_req_data, bus.store_succeeded_rob_tag);
        end
`ifdef STQ_DRAIN_PERF_COUNTER_EN
        total++;
        if (drained_count !== 32'd0 || retry_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters: drained=%0d retry=%0d want 0 0", drained_count, retry_count);
        end
`endif
        tick();
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.store_succeeded !== 1'b0 || bus.drain_busy !== 1'b0) hits++;
        end
        bus.mem_resp_valid = 1'b0;
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL stray_resp: active cycles=%0d want 0", hits);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int gap = 0;
        bus.mem_req_ready = 1'b1;
        set_head(32'h6000, 32'h60, 6'd1);
        for (int c = 0; c < 40 && n < 3; c++) begin
            tick();
            if (gap == 1) begin
                total++;
                if (bus.drain_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_gap_idle[%0d]: busy=%b want 0", n, bus.drain_busy);
                end
                gap = 2;
            end else if (gap == 2) begin
                total++;
                if (bus.mem_req_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_gap_req[%0d]: valid=%b want 1", n, bus.mem_req_valid);
                end
                gap = 0;
            end
            if (bus.store_succeeded === 1'b1) begin
                total++;
                if (bus.store_succeeded_rob_tag !== 6'(n + 1)) begin
                    bad++;
                    $display("FAIL b2b_order[%0d]: tag=%0d want %0d", n, bus.store_succeeded_rob_tag, n + 1);
                end
                n++;
                if (n < 3) set_head(32'h6000 + 32'(n * 4), 32'h60 + 32'(n), 6'(n + 1));
                else bus.head_valid = 1'b0;
                gap = n < 3 ? 1 : 0;
            end
            bus.mem_resp_valid = bus.drain_busy && !bus.mem_req_valid && !bus.store_succeeded;
        end
        bus.mem_resp_valid = 1'b0;
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL b2b_count: retirements=%0d want 3", n);
        end
`ifdef STQ_DRAIN_PERF_COUNTER_EN
        total++;
        if (drained_count !== 32'd3) begin
            bad++;
            $display("FAIL drained_count: got %0d want 3", drained_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_ready_stall();
        test_error_retry();
        test_no_drain();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
